odd_parity_tx_ctrl: RTL and testbench

//  Serial transmit controller built around the odd-parity generator.
//  - Accepts one WIDTH-bit word per valid/ready handshake.
//  - Computes the word's odd-parity bit.
//  - Sequences a serial frame: start, data LSB-first, parity, stop.
//  - Sits between a word producer and a single-wire link; the link's receiver checks odd parity.

---
 rtl/odd_parity_tx_ctrl.sv | 92 +++++++++
 tb/tb_odd_parity_tx_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/odd_parity_tx_ctrl.sv
// Serial transmit controller: accepts a word over valid/ready and sends
// start, data LSB-first, odd parity and stop, each held CLKS_PER_BIT cycles.
module odd_parity_tx_ctrl #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             tx_serial,
    output logic             tx_busy,
    output logic             frame_done
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]      state;
    logic [CW-1:0]   cyc;
    logic [BW-1:0]   bit_idx;
    logic [WIDTH:0]  shreg;
    logic            cyc_last;

    assign cyc_last   = (cyc == CYC_LAST);
    assign in_ready   = (state == IDLE);
    assign tx_busy    = (state != IDLE);
    assign frame_done = (state == STOP) && cyc_last;

    // Parity rides at the top of the shift register so that after WIDTH
    // shifts it lands in bit 0, the same tap that drives the data bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cyc     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cyc     <= '0;
                    bit_idx <= '0;
                    if (in_valid) begin
                        shreg <= {~^in_data, in_data};
                        state <= START;
                    end
                end
                START, DATA, PARITY, STOP: begin
                    if (!cyc_last) begin
                        cyc <= cyc + CW'(1);
                    end else begin
                        cyc <= '0;
                        case (state)
                            START:  state <= DATA;
                            DATA: begin
                                shreg <= shreg >> 1;
                                if (bit_idx == BIT_LAST) begin
                                    bit_idx <= '0;
                                    state   <= PARITY;
                                end else begin
                                    bit_idx <= bit_idx + BW'(1);
                                end
                            end
                            PARITY: state <= STOP;
                            default: state <= IDLE;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        tx_serial = 1'b1;
        case (state)
            START:        tx_serial = 1'b0;
            DATA, PARITY: tx_serial = shreg[0];
            default:      tx_serial = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_odd_parity_tx_ctrl.sv
// Self-checking bench for odd_parity_tx_ctrl: directed and random frames
// compared against a bit-list model of the serial frame.
module tb_odd_parity_tx_ctrl;

    localparam int W   = 4;
    localparam int CPB = 4;
    localparam int FRAME = (W + 3) * CPB;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         tx_serial;
    logic         tx_busy;
    logic         frame_done;

    int compared   = 0;
    int mismatched = 0;

    odd_parity_tx_ctrl #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .tx_serial (tx_serial),
        .tx_busy   (tx_busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Line level in frame cycle k (0-based) for word w.
    function automatic logic model_bit(input logic [W-1:0] w, input int k);
        int b;
        b = k / CPB;
        if (b == 0)      return 1'b0;
        if (b <= W)      return w[b-1];
        if (b == W + 1)  return ($countones(w) % 2 == 0);
        return 1'b1;
    endfunction

    // Present w at a negedge; the following posedge accepts it. Checks the
    // whole frame and the idle cycle after it.
    task automatic send(input logic [W-1:0] w, input bit keep_valid,
                        input logic [W-1:0] nxt);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        if (!keep_valid) in_valid = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            in_data = keep_valid ? nxt : W'($urandom);
            check($sformatf("serial w=%b k=%0d", w, k), tx_serial, model_bit(w, k));
            check($sformatf("busy k=%0d", k), tx_busy, 1'b1);
            check($sformatf("done k=%0d", k), frame_done, k == FRAME - 1);
            check($sformatf("ready k=%0d", k), in_ready, 1'b0);
            @(negedge clk);
        end
        check("idle_ready", in_ready, 1'b1);
        check("idle_busy", tx_busy, 1'b0);
        check("idle_serial", tx_serial, 1'b1);
        check("idle_done", frame_done, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        repeat (2) begin
            @(negedge clk);
            check("rst_serial", tx_serial, 1'b1);
            check("rst_busy", tx_busy, 1'b0);
            check("rst_done", frame_done, 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("rel_ready", in_ready, 1'b1);

        send(4'b0000, 1'b0, '0);
        send(4'b0001, 1'b0, '0);
        send(4'b1010, 1'b0, '0);
        send(4'b1111, 1'b0, '0);
        send(4'b0111, 1'b0, '0);

        // Back-to-back with in_valid held: second word goes one cycle after frame_done.
        send(4'b1010, 1'b1, 4'b0111);
        send(4'b0111, 1'b0, '0);

        repeat (8) send(W'($urandom), 1'b0, '0);

        // Reset in the middle of a frame aborts it.
        in_valid = 1'b1;
        in_data  = 4'b1001;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("abort_pre", tx_serial, model_bit(4'b1001, k));
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_serial", tx_serial, 1'b1);
        check("abort_busy", tx_busy, 1'b0);
        check("abort_ready", in_ready, 1'b1);
        check("abort_done", frame_done, 1'b0);
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            check("abort_quiet_done", frame_done, 1'b0);
            check("abort_quiet_serial", tx_serial, 1'b1);
        end

        // Reset coincident with valid: nothing accepted.
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 4'b0110;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        check("rstv_busy", tx_busy, 1'b0);
        check("rstv_serial", tx_serial, 1'b1);
        @(negedge clk);
        check("rstv_busy2", tx_busy, 1'b0);

        send(4'b0110, 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
